// File: rtl/rn_dp_queue.sv
// rn_dp_queue -- rename->dispatch decoupling queue.
//
// Holds up to DEPTH renamed micro-ops between rename (producer) and
// dispatch/RS allocation (consumer). Both sides use a valid/ready handshake.
// While an op waits in the queue, its operands snoop the CDB: a non-ready
// operand whose tag matches a broadcast captures the value and becomes ready.
// The head operands also see a same-cycle CDB match combinationally, so
// dispatch never misses a result that arrives in the cycle it takes the op.
//
// Ports
//   clk_i, rst_i (async, active-high), flush_i (synchronous squash)
//   in_valid_i / in_ready_o / in_payload_i                 producer handshake + body
//   in_op{a,b}_rdy_i / _value_i / _tag_i                    incoming operands
//   cdb_valid_i / cdb_tag_i / cdb_value_i                   result broadcast
//   out_valid_o / out_ready_i / out_payload_o               consumer handshake + body
//   out_op{a,b}_rdy_o / _value_o / _tag_o                   head operands (CDB bypassed)
//   count_o                                                 occupied entries

`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

module rn_dp_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 128,
    parameter int ROB_W     = `ROB_ENTRY_WIDTH,
    parameter int DATA_W    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [PAYLOAD_W-1:0]       in_payload_i,
    input  logic                       in_opa_rdy_i,
    input  logic [DATA_W-1:0]          in_opa_value_i,
    input  logic [ROB_W-1:0]           in_opa_tag_i,
    input  logic                       in_opb_rdy_i,
    input  logic [DATA_W-1:0]          in_opb_value_i,
    input  logic [ROB_W-1:0]           in_opb_tag_i,
    input  logic                       cdb_valid_i,
    input  logic [ROB_W-1:0]           cdb_tag_i,
    input  logic [DATA_W-1:0]          cdb_value_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PAYLOAD_W-1:0]       out_payload_o,
    output logic                       out_opa_rdy_o,
    output logic [DATA_W-1:0]          out_opa_value_o,
    output logic [ROB_W-1:0]           out_opa_tag_o,
    output logic                       out_opb_rdy_o,
    output logic [DATA_W-1:0]          out_opb_value_o,
    output logic [ROB_W-1:0]           out_opb_tag_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Operand inputs gathered into arrays so both operands share one
    // generate body; index 0 is operand A, index 1 is operand B.
    logic [1:0]        in_rdy;
    logic [DATA_W-1:0] in_val [2];
    logic [ROB_W-1:0]  in_tag [2];

    assign in_rdy    = {in_opb_rdy_i, in_opa_rdy_i};
    assign in_val[0] = in_opa_value_i;
    assign in_val[1] = in_opb_value_i;
    assign in_tag[0] = in_opa_tag_i;
    assign in_tag[1] = in_opb_tag_i;

    // Entry storage, flattened so operand j of entry i lives at 2*i+j.
    logic [DEPTH-1:0]     valid_q;
    logic [PAYLOAD_W-1:0] payload_arr [DEPTH];
    logic [2*DEPTH-1:0]   opr_rdy;
    logic [DATA_W-1:0]    opr_val [2*DEPTH];
    logic [ROB_W-1:0]     opr_tag [2*DEPTH];

    assign in_ready_o  = !flush_i && (count_q < CW'(DEPTH));
    assign out_valid_o = !flush_i && (count_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign count_d     = count_q + CW'(push) - CW'(pop);
    assign count_o     = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic                 wr_sel, rd_sel;
            logic [PAYLOAD_W-1:0] pl_q;

            assign wr_sel = push && (wr_ptr_q == PW'(gi));
            assign rd_sel = pop  && (rd_ptr_q == PW'(gi));

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)        valid_q[gi] <= 1'b0;
                else if (flush_i) valid_q[gi] <= 1'b0;
                else if (wr_sel)  valid_q[gi] <= 1'b1;
                else if (rd_sel)  valid_q[gi] <= 1'b0;
            end

            // Body is qualified by valid_q/out_valid, so it needs no reset.
            always_ff @(posedge clk_i) begin
                if (wr_sel) pl_q <= in_payload_i;
            end
            assign payload_arr[gi] = pl_q;

            for (gj = 0; gj < 2; gj++) begin : g_opr
                logic              rdy_q;
                logic [DATA_W-1:0] val_q;
                logic [ROB_W-1:0]  tag_q;
                logic              wake, in_hit;

                assign wake   = valid_q[gi] && !rdy_q && cdb_valid_i && (cdb_tag_i == tag_q);
                // An operand pushed while its producer broadcasts must
                // capture that result now; it will never be broadcast again.
                assign in_hit = !in_rdy[gj] && cdb_valid_i && (cdb_tag_i == in_tag[gj]);

                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i)       rdy_q <= 1'b0;
                    else if (wr_sel) rdy_q <= in_rdy[gj] | in_hit;
                    else if (wake)   rdy_q <= 1'b1;
                end

                always_ff @(posedge clk_i) begin
                    if (wr_sel) begin
                        tag_q <= in_tag[gj];
                        val_q <= in_hit ? cdb_value_i : in_val[gj];
                    end else if (wake) begin
                        val_q <= cdb_value_i;
                    end
                end

                assign opr_rdy[2*gi+gj] = rdy_q;
                assign opr_val[2*gi+gj] = val_q;
                assign opr_tag[2*gi+gj] = tag_q;
            end
        end
    endgenerate

    // Head read with same-cycle CDB bypass; all fields forced to 0 when empty.
    logic              head_rdy [2];
    logic [DATA_W-1:0] head_val [2];
    logic [ROB_W-1:0]  head_tag [2];

    generate
        for (gj = 0; gj < 2; gj++) begin : g_head
            logic [PW:0] hidx;
            logic        hit;

            assign hidx = {rd_ptr_q, 1'(gj)};
            assign hit  = !opr_rdy[hidx] && cdb_valid_i && (cdb_tag_i == opr_tag[hidx]);

            assign head_rdy[gj] = out_valid_o && (opr_rdy[hidx] || hit);
            assign head_val[gj] = !out_valid_o ? '0 : (hit ? cdb_value_i : opr_val[hidx]);
            assign head_tag[gj] = out_valid_o ? opr_tag[hidx] : '0;
        end
    endgenerate

    assign out_payload_o   = out_valid_o ? payload_arr[rd_ptr_q] : '0;
    assign out_opa_rdy_o   = head_rdy[0];
    assign out_opa_value_o = head_val[0];
    assign out_opa_tag_o   = head_tag[0];
    assign out_opb_rdy_o   = head_rdy[1];
    assign out_opb_value_o = head_val[1];
    assign out_opb_tag_o   = head_tag[1];

endmodule

// File: tb/tb_rn_dp_queue.sv
// Testbench for rn_dp_queue: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.

module tb_rn_dp_queue;

    localparam int DEPTH = 4;
    localparam int PLW   = 128;
    localparam int RW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [PLW-1:0] in_payload;
    logic          in_opa_rdy, in_opb_rdy;
    logic [DW-1:0] in_opa_value, in_opb_value;
    logic [RW-1:0] in_opa_tag, in_opb_tag;
    logic          cdb_valid;
    logic [RW-1:0] cdb_tag;
    logic [DW-1:0] cdb_value;
    logic          in_ready, out_valid;
    logic [PLW-1:0] out_payload;
    logic          out_opa_rdy, out_opb_rdy;
    logic [DW-1:0] out_opa_value, out_opb_value;
    logic [RW-1:0] out_opa_tag, out_opb_tag;
    logic [2:0]    count;

    always #5 clk = ~clk;

    rn_dp_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PLW), .ROB_W(RW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_payload_i(in_payload),
        .in_opa_rdy_i(in_opa_rdy), .in_opa_value_i(in_opa_value), .in_opa_tag_i(in_opa_tag),
        .in_opb_rdy_i(in_opb_rdy), .in_opb_value_i(in_opb_value), .in_opb_tag_i(in_opb_tag),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_payload_o(out_payload),
        .out_opa_rdy_o(out_opa_rdy), .out_opa_value_o(out_opa_value), .out_opa_tag_o(out_opa_tag),
        .out_opb_rdy_o(out_opb_rdy), .out_opb_value_o(out_opb_value), .out_opb_tag_o(out_opb_tag),
        .count_o(count)
    );

    typedef struct packed {
        logic [PLW-1:0]       pl;
        logic [1:0]           rdy;
        logic [1:0][DW-1:0]   val;
        logic [1:0][RW-1:0]   tag;
    } ent_t;

    ent_t           model_q[$];
    logic [PLW-1:0] popped[$];
    int             checks = 0;
    int             errors = 0;
    logic           exp_push, exp_pop, last_push;

    task automatic chk(input string nm, input logic [PLW-1:0] act, input logic [PLW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // A waiting operand whose producer is on the CDB now becomes ready.
    function automatic ent_t wake(input ent_t e);
        ent_t r = e;
        for (int k = 0; k < 2; k++)
            if (!r.rdy[k] && cdb_valid && r.tag[k] == cdb_tag) begin
                r.rdy[k] = 1'b1;
                r.val[k] = cdb_value;
            end
        return r;
    endfunction

    // Compare all DUT outputs with what the model says they must be now.
    task automatic check_now();
        ent_t h;
        logic exp_ir, exp_ov;
        #1;
        exp_ir = !flush && (model_q.size() < DEPTH);
        exp_ov = !flush && (model_q.size() != 0);
        h      = exp_ov ? wake(model_q[0]) : '0;
        chk("in_ready",  in_ready,      exp_ir);
        chk("out_valid", out_valid,     exp_ov);
        chk("count",     count,         model_q.size());
        chk("payload",   out_payload,   h.pl);
        chk("opa_rdy",   out_opa_rdy,   h.rdy[0]);
        chk("opa_value", out_opa_value, h.val[0]);
        chk("opa_tag",   out_opa_tag,   h.tag[0]);
        chk("opb_rdy",   out_opb_rdy,   h.rdy[1]);
        chk("opb_value", out_opb_value, h.val[1]);
        chk("opb_tag",   out_opb_tag,   h.tag[1]);
        exp_push = in_valid && exp_ir;
        exp_pop  = exp_ov && out_ready;
    endtask

    // Clock edge: update the model from the inputs held across it.
    task automatic advance();
        ent_t n;
        @(posedge clk);
        if (flush) begin
            model_q.delete();
        end else begin
            foreach (model_q[i]) model_q[i] = wake(model_q[i]);
            if (exp_pop) popped.push_back(model_q.pop_front().pl);
            if (exp_push) begin
                n.pl  = in_payload;
                n.rdy = {in_opb_rdy, in_opa_rdy};
                n.val = {in_opb_value, in_opa_value};
                n.tag = {in_opb_tag, in_opa_tag};
                model_q.push_back(wake(n));
            end
        end
        last_push = exp_push;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; out_ready = 0; cdb_valid = 0;
        cdb_tag = '0; cdb_value = '0; in_payload = '0;
        in_opa_rdy = 1; in_opa_value = '0; in_opa_tag = '0;
        in_opb_rdy = 1; in_opb_value = '0; in_opb_tag = '0;
    endtask

    task automatic do_flush();
        idle_inputs(); flush = 1; check_now(); advance(); flush = 0;
    endtask

    task automatic push_one(input logic [PLW-1:0] p);
        in_valid = 1; in_payload = p; check_now(); advance(); in_valid = 0;
    endtask

    initial begin
        bit got5;
        rst = 1; idle_inputs();
        repeat (2) @(negedge clk);
        rst = 0;

        // 1: asynchronous reset with three entries queued
        push_one(128'hA1); push_one(128'hA2); push_one(128'hA3);
        check_now();
        chk("pre_rst_count", count, 3);
        #2 rst = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count",     count,     0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_payload",   out_payload, 0);
        model_q.delete();
        @(negedge clk); rst = 0;

        // 2: fill past capacity, then drain in order
        popped.delete();
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1; in_payload = PLW'(i); check_now(); advance();
        end
        check_now();
        chk("full_count",    count,    4);
        chk("full_in_ready", in_ready, 0);
        out_ready = 1; got5 = 0;
        for (int c = 0; c < 20 && popped.size() < 5; c++) begin
            in_valid = !got5; check_now();
            if (c == 0) chk("full_pop_in_ready", in_ready, 0);
            advance();
            if (last_push) got5 = 1;
        end
        chk("drain_len", popped.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("drain_order", (i < popped.size()) ? popped[i] : '1, PLW'(i + 1));
        idle_inputs();

        // 3: buffered operand A wakes from the CDB, bypassed at the head
        do_flush();
        in_opa_rdy = 0; in_opa_tag = 7; in_opa_value = 32'h1111;
        push_one(128'hB0);
        idle_inputs();
        cdb_valid = 1; cdb_tag = 7; cdb_value = 32'hDEADBEEF;
        check_now();
        chk("bypass_opa_rdy",   out_opa_rdy,   1);
        chk("bypass_opa_value", out_opa_value, 32'hDEADBEEF);
        advance();
        cdb_valid = 0;
        check_now();
        chk("held_opa_rdy",   out_opa_rdy,   1);
        chk("held_opa_value", out_opa_value, 32'hDEADBEEF);
        advance();

        // 4: push-cycle snoop of operand B
        do_flush();
        in_opb_rdy = 0; in_opb_tag = 3; in_opb_value = 32'h99;
        cdb_valid = 1; cdb_tag = 3; cdb_value = 32'h55;
        push_one(128'hC0);
        idle_inputs();
        check_now();
        chk("snoop_opb_rdy",   out_opb_rdy,   1);
        chk("snoop_opb_value", out_opb_value, 32'h55);
        advance();

        // 5: flush dominates a simultaneous push and pop
        do_flush();
        push_one(128'hD1); push_one(128'hD2);
        flush = 1; in_valid = 1; out_ready = 1; in_payload = 128'hD3;
        check_now();
        chk("flush_in_ready",  in_ready,  0);
        chk("flush_out_valid", out_valid, 0);
        advance();
        idle_inputs();
        check_now();
        chk("post_flush_count", count,     0);
        chk("post_flush_valid", out_valid, 0);
        advance();

        // 6: streaming push+pop keeps count fixed across pointer wrap
        popped.delete();
        push_one(128'd100);
        in_valid = 1; out_ready = 1;
        for (int c = 0; c < 3 * DEPTH; c++) begin
            in_payload = PLW'(101 + c);
            check_now();
            chk("stream_count", count, 1);
            advance();
        end
        chk("stream_len", popped.size(), 3 * DEPTH);
        for (int i = 0; i < 3 * DEPTH; i++)
            chk("stream_order", (i < popped.size()) ? popped[i] : '1, PLW'(100 + i));
        idle_inputs();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            flush        = ($urandom_range(0, 39) == 0);
            in_valid     = $urandom_range(0, 2) != 0;
            out_ready    = $urandom_range(0, 2) != 0;
            in_payload   = {$urandom, $urandom, $urandom, $urandom};
            in_opa_rdy   = $urandom_range(0, 1);
            in_opa_value = $urandom;
            in_opa_tag   = RW'($urandom_range(0, 7));
            in_opb_rdy   = $urandom_range(0, 1);
            in_opb_value = $urandom;
            in_opb_tag   = RW'($urandom_range(0, 7));
            cdb_valid    = $urandom_range(0, 1);
            cdb_tag      = RW'($urandom_range(0, 7));
            cdb_value    = $urandom;
            check_now();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
